// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone parallel-prefix adder with valid/ready stream and sideband tag.
// Optional `define PPA_SUB_EN enables subtract (a - b) selected per operation by sub.
module pipelined_prefix_adder #(
    parameter int WIDTH       = 64,
    parameter int LVL_PER_STG = 2,
    parameter int USER_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    input  logic              sub,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  sum,
    output logic              cout,
    output logic              ovf,
    output logic [USER_W-1:0] out_user
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int NSTG   = (LEVELS + LVL_PER_STG - 1) / LVL_PER_STG;
    localparam int NR     = (NSTG > 1) ? NSTG - 1 : 1;

    logic              adv;
    logic [WIDTH-1:0]  bx;
    logic              cx;
    logic [WIDTH-1:0]  g0;
    logic [WIDTH-1:0]  p0;

    logic [NSTG-1:0]   v_q;
    logic [USER_W-1:0] u_q  [NSTG];
    logic [WIDTH-1:0]  g_q  [NR];
    logic [WIDTH-1:0]  pp_q [NR];
    logic [WIDTH-1:0]  hp_q [NR];
    logic [NR-1:0]     c_q;

    logic [WIDTH-1:0]  gin  [NSTG];
    logic [WIDTH-1:0]  pin  [NSTG];
    logic [WIDTH-1:0]  go   [NSTG];
    logic [WIDTH-1:0]  po   [NSTG];
    logic [WIDTH-1:0]  gt;
    logic [WIDTH-1:0]  pt;

    logic [WIDTH-1:0]  hp_l;
    logic              c_l;
    logic [WIDTH-1:0]  carry;
    logic [WIDTH-1:0]  sum_d;
    logic              cout_d;
    logic              ovf_d;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic [WIDTH-1:0]  unused_plast;

    assign out_valid    = v_q[NSTG-1];
    assign adv          = !out_valid || out_ready;
    assign in_ready     = adv;
    assign out_user     = u_q[NSTG-1];
    assign sum          = sum_q;
    assign cout         = cout_q;
    assign ovf          = ovf_q;
    assign unused_plast = po[NSTG-1];

`ifdef PPA_SUB_EN
    always_comb begin
        bx = sub ? ~b : b;
        cx = sub | cin;
    end
`else
    logic unused_sub;
    assign unused_sub = sub;
    always_comb begin
        bx = b;
        cx = cin;
    end
`endif

    // cin folds into bit 0 so the prefix tree yields carries directly
    always_comb begin
        p0    = a ^ bx;
        g0    = a & bx;
        g0[0] = g0[0] | (p0[0] & cx);
    end

    always_comb begin
        gin[0] = g0;
        pin[0] = p0;
        for (int s = 1; s < NSTG; s++) begin
            gin[s] = g_q[s-1];
            pin[s] = pp_q[s-1];
        end
    end

    always_comb begin
        gt = '0;
        pt = '0;
        for (int s = 0; s < NSTG; s++) begin
            gt = gin[s];
            pt = pin[s];
            for (int k = s * LVL_PER_STG; k < (s + 1) * LVL_PER_STG; k++) begin
                if (k < LEVELS) begin
                    gt = gt | (pt & (gt << (1 << k)));
                    pt = pt & ((pt << (1 << k)) | ~({WIDTH{1'b1}} << (1 << k)));
                end
            end
            go[s] = gt;
            po[s] = pt;
        end
    end

    always_comb begin
        hp_l   = (NSTG > 1) ? hp_q[NR-1] : p0;
        c_l    = (NSTG > 1) ? c_q[NR-1]  : cx;
        carry  = {go[NSTG-1][WIDTH-2:0], c_l};
        sum_d  = hp_l ^ carry;
        cout_d = go[NSTG-1][WIDTH-1];
        ovf_d  = carry[WIDTH-1] ^ cout_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            c_q    <= '0;
            for (int s = 0; s < NSTG; s++) u_q[s] <= '0;
            for (int r = 0; r < NR; r++) begin
                g_q[r]  <= '0;
                pp_q[r] <= '0;
                hp_q[r] <= '0;
            end
        end else if (adv) begin
            v_q[0] <= in_valid;
            u_q[0] <= in_user;
            for (int s = 1; s < NSTG; s++) begin
                v_q[s] <= v_q[s-1];
                u_q[s] <= u_q[s-1];
            end
            if (NSTG > 1) begin
                hp_q[0] <= p0;
                c_q[0]  <= cx;
                for (int r = 1; r < NR; r++) begin
                    hp_q[r] <= hp_q[r-1];
                    c_q[r]  <= c_q[r-1];
                end
                for (int r = 0; r < NR; r++) begin
                    g_q[r]  <= go[r];
                    pp_q[r] <= po[r];
                end
            end
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule
